// File: rtl/alu_control_unit.sv
// Sequencing front end for the combinational ALU. It accepts one request, drives the ALU
// for a single execute cycle, then holds the result, the flag register and the condition outcome.
module alu_control_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_set_flags,
    input  logic [3:0]       req_cond,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_function_select,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_f,
    input  logic [3:0]       alu_status,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cond_true,
    output logic [3:0]       flags
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [4:0]       fsel_q, fsel_d;
    logic             cin_q, cin_d;
    logic             set_flags_q;
    logic [3:0]       cond_q;
    logic [3:0]       flags_q, flags_d;
    logic             cond_true_q, cond_true_d;
    logic             accept;

    // Flags are packed {v,c,n,z}.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic v, c, n, z, res;
        {v, c, n, z} = f;
        case (cond)
            4'd0:    res = z;
            4'd1:    res = !z;
            4'd2:    res = c;
            4'd3:    res = !c;
            4'd4:    res = n;
            4'd5:    res = !n;
            4'd6:    res = v;
            4'd7:    res = !v;
            4'd8:    res = c && !z;
            4'd9:    res = !c || z;
            4'd10:   res = (n == v);
            4'd11:   res = (n != v);
            4'd12:   res = !z && (n == v);
            4'd13:   res = z || (n != v);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    always_comb begin
        fsel_d = 5'b00000;
        cin_d  = 1'b0;
        case (req_op)
            3'd0: fsel_d = 5'b00000;
            3'd1: fsel_d = 5'b00100;
            3'd2: fsel_d = 5'b01000;
            3'd3: begin
                fsel_d = 5'b01010;
                cin_d  = 1'b1;
            end
            3'd4: fsel_d = 5'b01100;
            3'd5: fsel_d = 5'b10000;
            3'd6: fsel_d = 5'b10100;
            3'd7: fsel_d = 5'b00010;
            default: fsel_d = 5'b00000;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = EXEC;
            end
            EXEC: state_d = RESP;
            RESP: begin
                // Consuming the response frees the unit in the same cycle.
                req_ready = rsp_ready;
                if (rsp_ready) state_d = req_valid ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept      = req_valid && req_ready;
    assign flags_d     = set_flags_q ? alu_status : flags_q;
    assign cond_true_d = cond_eval(cond_q, flags_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            fsel_q      <= 5'b00000;
            cin_q       <= 1'b0;
            set_flags_q <= 1'b0;
            cond_q      <= 4'd0;
            result_q    <= '0;
            flags_q     <= 4'b0000;
            cond_true_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q         <= req_a;
                b_q         <= req_b;
                fsel_q      <= fsel_d;
                cin_q       <= cin_d;
                set_flags_q <= req_set_flags;
                cond_q      <= req_cond;
            end
            if (state_q == EXEC) begin
                result_q    <= alu_f;
                flags_q     <= flags_d;
                cond_true_q <= cond_true_d;
            end
        end
    end

    assign alu_a               = a_q;
    assign alu_b               = b_q;
    assign alu_function_select = fsel_q;
    assign alu_cin             = cin_q;
    assign rsp_valid           = (state_q == RESP);
    assign rsp_result          = result_q;
    assign rsp_cond_true       = cond_true_q;
    assign flags               = flags_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: a behavioural ALU stub, an operation-level reference model
// checked every cycle, directed literal cases and a randomized traffic phase.
module tb_alu_control_unit;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   req_op = 3'd0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         req_set_flags = 1'b0;
    logic [3:0]   req_cond = 4'd0;
    logic [W-1:0] alu_a, alu_b, alu_f;
    logic [4:0]   alu_function_select;
    logic         alu_cin;
    logic [3:0]   alu_status;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_result;
    logic         rsp_cond_true;
    logic [3:0]   flags;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_control_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_set_flags(req_set_flags), .req_cond(req_cond),
        .alu_a(alu_a), .alu_b(alu_b), .alu_function_select(alu_function_select),
        .alu_cin(alu_cin), .alu_f(alu_f), .alu_status(alu_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cond_true(rsp_cond_true), .flags(flags)
    );

    // ALU stub driven purely by function_select/cin
    logic [W-1:0] s_a, s_b;
    logic [W:0]   s_sum;
    logic         s_c, s_v;
    always_comb begin
        s_a   = alu_function_select[0] ? ~alu_a : alu_a;
        s_b   = alu_function_select[1] ? ~alu_b : alu_b;
        s_sum = {1'b0, s_a} + {1'b0, s_b} + {{W{1'b0}}, alu_cin};
        s_c   = 1'b0;
        s_v   = 1'b0;
        alu_f = '0;
        case (alu_function_select[4:2])
            3'd0: alu_f = s_a & s_b;
            3'd1: alu_f = s_a | s_b;
            3'd2: begin
                alu_f = s_sum[W-1:0];
                s_c   = s_sum[W];
                s_v   = (s_a[W-1] == s_b[W-1]) && (alu_f[W-1] != s_a[W-1]);
            end
            3'd3: alu_f = s_a ^ s_b;
            3'd4: alu_f = s_a << s_b[5:0];
            3'd5: alu_f = s_a >> s_b[5:0];
            default: alu_f = '0;
        endcase
        alu_status = {s_v, s_c, alu_f[W-1], (alu_f == '0)};
    end

    // Operation semantics: returns {v,c,n,z,result}
    function automatic logic [67:0] ref_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [64:0] wide;
        logic [63:0] r;
        logic c, v;
        c = 1'b0; v = 1'b0; r = '0; wide = '0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[63:0];
                c = wide[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'd3: begin
                r = a - b;
                c = (a >= b);
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'd4: r = a ^ b;
            3'd5: r = a << b[5:0];
            3'd6: r = a >> b[5:0];
            default: r = a & ~b;
        endcase
        return {v, c, r[63], (r == '0), r};
    endfunction

    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic v, c, n, z;
        {v, c, n, z} = f;
        case (cc)
            4'd0: return z;
            4'd1: return !z;
            4'd2: return c;
            4'd3: return !c;
            4'd4: return n;
            4'd5: return !n;
            4'd6: return v;
            4'd7: return !v;
            4'd8: return c & !z;
            4'd9: return !c | z;
            4'd10: return n ~^ v;
            4'd11: return n ^ v;
            4'd12: return !z & (n ~^ v);
            4'd13: return z | (n ^ v);
            default: return 1'b1;
        endcase
    endfunction

    // {function_select, cin} per operation code
    function automatic logic [5:0] ctl_of(input logic [2:0] op);
        case (op)
            3'd0: return 6'b000000;
            3'd1: return 6'b001000;
            3'd2: return 6'b010000;
            3'd3: return 6'b010101;
            3'd4: return 6'b011000;
            3'd5: return 6'b100000;
            3'd6: return 6'b101000;
            default: return 6'b000100;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one op in execution and/or one held response
    logic        m_busy = 1'b0, m_resp = 1'b0, m_set = 1'b0, m_ctrue = 1'b0;
    logic [2:0]  m_op = 3'd0;
    logic [63:0] m_a = '0, m_b = '0, m_result = '0;
    logic [3:0]  m_cond = 4'd0, m_flags = 4'd0;

    initial begin
        logic        exp_ready;
        logic [67:0] o;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_ready = !m_busy && (!m_resp || rsp_ready);
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_resp));
            chk("flags", 64'(flags), 64'(m_flags));
            chk("rsp_result", rsp_result, m_result);
            chk("rsp_cond_true", 64'(rsp_cond_true), 64'(m_ctrue));
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_ctl", 64'({alu_function_select, alu_cin}), 64'(ctl_of(m_op)));
            if (reset) begin
                m_busy = 0; m_resp = 0; m_set = 0; m_ctrue = 0; m_op = 0;
                m_a = '0; m_b = '0; m_result = '0; m_cond = 0; m_flags = 0;
            end else if (m_busy) begin
                o = ref_op(m_op, m_a, m_b);
                if (m_set) m_flags = o[67:64];
                m_result = o[63:0];
                m_ctrue  = cond_ok(m_cond, m_flags);
                m_busy   = 0;
                m_resp   = 1;
            end else begin
                if (m_resp && rsp_ready) m_resp = 0;
                if (exp_ready && req_valid) begin
                    m_busy = 1; m_op = req_op; m_a = req_a; m_b = req_b;
                    m_set = req_set_flags; m_cond = req_cond;
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic sf, input logic [3:0] cc);
        logic acc;
        acc = 1'b0;
        req_op = op; req_a = a; req_b = b; req_set_flags = sf; req_cond = cc;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    // Called right after send with rsp_ready high; returns at posedge+1 after consumption.
    task automatic get_rsp(input string nm, input logic [63:0] er, input logic [3:0] ef,
                           input logic ec, output logic [5:0] ctl_exec);
        int  n;
        logic got;
        n = 0; got = 1'b0; ctl_exec = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) ctl_exec = {alu_function_select, alu_cin};
            got = rsp_valid;
        end
        chk({nm, "_latency"}, 64'(n), 64'd2);
        chk({nm, "_result"}, rsp_result, er);
        chk({nm, "_flags"}, 64'(flags), 64'(ef));
        chk({nm, "_cond"}, 64'(rsp_cond_true), 64'(ec));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return '1;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [5:0] ctl;
        logic       got;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_ctl", 64'({alu_function_select, alu_cin}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        send(3'd3, 64'd5, 64'd5, 1'b1, 4'd0);
        get_rsp("sub_eq", 64'd0, 4'b0101, 1'b1, ctl);
        chk("sub_exec_ctl", 64'(ctl), 64'b010101);
        send(3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd10);
        get_rsp("add_ge", 64'h8000_0000_0000_0000, 4'b1010, 1'b1, ctl);
        send(3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd11);
        get_rsp("add_lt", 64'h8000_0000_0000_0000, 4'b1010, 1'b0, ctl);
        send(3'd5, 64'd1, 64'd63, 1'b0, 4'd6);
        get_rsp("lsl_vs", 64'h8000_0000_0000_0000, 4'b1010, 1'b1, ctl);

        // Backpressure with a second request waiting
        rsp_ready = 1'b0;
        send(3'd2, 64'd10, 64'd20, 1'b0, 4'd14);
        req_op = 3'd0; req_a = 64'hFF; req_b = 64'h0F; req_set_flags = 1'b1; req_cond = 4'd0;
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        chk("bp_rsp_seen", 64'(got), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_result", rsp_result, 64'd30);
            chk("bp_flags", 64'(flags), 64'b1010);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_exec", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("bp_next_valid", 64'(rsp_valid), 64'd1);
        chk("bp_next_result", rsp_result, 64'h0F);
        chk("bp_next_flags", 64'(flags), 64'b0000);
        chk("bp_next_cond", 64'(rsp_cond_true), 64'd0);
        @(posedge clk);
        #1;

        // Reset during EXEC of a flag-setting SUB
        send(3'd3, 64'd9, 64'd2, 1'b1, 4'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rx_req_ready", 64'(req_ready), 64'd1);
        chk("rx_flags", 64'(flags), 64'd0);
        for (int i = 0; i < 6; i++) begin
            chk("rx_no_rsp", 64'(rsp_valid), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            req_valid     = ($urandom_range(0, 9) < 7);
            req_op        = 3'($urandom_range(0, 7));
            req_a         = rnd_val();
            req_b         = rnd_val();
            req_set_flags = 1'($urandom_range(0, 1));
            req_cond      = 4'($urandom_range(0, 15));
            rsp_ready     = ($urandom_range(0, 9) < 7);
            reset         = ($urandom_range(0, 199) == 0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
